multi_debounce_filter: RTL and testbench
========================================

MULTI_DEBOUNCE_FILTER -- requirements
Module: multi_debounce_filter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent debounced channels, minimum 1.
REQ-002 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000: clock cycles of input stability required before the output changes, minimum 2.
REQ-003 The block SHALL have parameter HOLD_LIMIT, default 25000000: clock cycles of debounced-high before long-press is flagged, minimum 1.
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port i_Bouncy, input, NUM_CH bits: raw switch levels, asynchronous to i_Clk.
REQ-007 The block SHALL have port o_Debounced, output, NUM_CH bits: filtered stable levels.
REQ-008 The block SHALL have port o_Rise, output, NUM_CH bits: one-cycle pulse per channel on a debounced 0->1 transition.
REQ-009 The block SHALL have port o_Fall, output, NUM_CH bits: one-cycle pulse per channel on a debounced 1->0 transition.
REQ-010 The block SHALL have port o_Hold, output, NUM_CH bits: long-press flag per channel.
REQ-011 The block SHALL have port o_Any_Change, output, 1 bit: OR-reduction of o_Rise | o_Fall.

Function
REQ-012 Each channel SHALL pass i_Bouncy through a 2-flop synchronizer (s1, s2) before any comparison.
REQ-013 Each channel SHALL use a counter of width $clog2(DEBOUNCE_LIMIT) that operates on every edge:
- s2 != o_Debounced and count < DEBOUNCE_LIMIT-1: increment the count.
- s2 != o_Debounced and count == DEBOUNCE_LIMIT-1: load o_Debounced <= s2 and clear the count.
- s2 == o_Debounced: clear the count.
REQ-014 Latency: with i_Bouncy held at a new level from edge k onward (counting edge k as edge 1), o_Debounced SHALL change at edge k+DEBOUNCE_LIMIT+1, i.e. on the DEBOUNCE_LIMIT+2-th edge.
REQ-015 Any return of s2 to the current o_Debounced level before the limit is reached SHALL restart the count from 0; no partial credit.
REQ-016 o_Rise/o_Fall SHALL be registered and high for exactly one cycle, coincident with the first cycle o_Debounced shows the new level.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce pulses on all of them in the same cycle.
REQ-018 o_Any_Change SHALL be combinational from the registered o_Rise/o_Fall, so it adds no cycle of latency.

Reset
REQ-019 While i_Rst is high, all synchronizer flops, all counters, o_Debounced, o_Rise, o_Fall and o_Hold SHALL be 0 immediately, without waiting for a clock edge.
REQ-020 Reset asserted mid-count SHALL discard progress; after release, a full DEBOUNCE_LIMIT count SHALL be required again, and no pulse SHALL be generated by reset itself.

Configuration
REQ-021 Macro MULTI_DEBOUNCE_HOLD_EN SHALL compile the long-press logic in or out.
REQ-022 With MULTI_DEBOUNCE_HOLD_EN defined, each channel SHALL have a saturating hold counter that:
- clears whenever o_Debounced is 0;
- counts cycles while o_Debounced is 1;
- sets o_Hold on the HOLD_LIMIT-th edge after the edge at which o_Debounced rose;
- keeps o_Hold high until the edge at which o_Debounced falls, where it clears together with that fall.
REQ-023 Without MULTI_DEBOUNCE_HOLD_EN, o_Hold SHALL be constant 0, no hold counters SHALL exist, and all other behaviour SHALL be unchanged.

Verification (NUM_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=8, macro defined unless stated)
REQ-024 Bench SHALL drive i_Bouncy[0]=1 stable from edge 3 -> o_Debounced[0] rises at edge 8; o_Rise[0] and o_Any_Change high only in cycle 8; channel 1 outputs stay 0.
REQ-025 Bench SHALL drive i_Bouncy[0] 1 for 1 cycle, 0 for 1 cycle, then 1 stable -> no output change during the bounce; exactly one o_Rise[0], 6 edges after the final 1 is applied.
REQ-026 Bench SHALL drive i_Bouncy[0]=1 for 3 cycles, then 0 -> o_Debounced, o_Rise and o_Fall stay 0 throughout.
REQ-027 Bench SHALL hold ch0 high past its debounce, then release -> o_Hold[0] rises 8 edges after o_Debounced[0] rose; on release, o_Fall[0] pulses and o_Hold[0] clears on the same edge; rerun with the macro undefined -> o_Hold stays 0.
REQ-028 Bench SHALL raise both channels on the same edge -> o_Rise=2'b11 in a single cycle and o_Any_Change pulses once.
REQ-029 Bench SHALL pulse i_Rst when ch0 count=2 -> all outputs 0 immediately; after release with input still 1 -> rise occurs 6 edges later, no pulse at reset.

Source files
------------

// File: rtl/multi_debounce_filter.sv
// Multi-channel switch debouncer with per-channel rise/fall pulses and optional long-press flag.
// Define MULTI_DEBOUNCE_HOLD_EN to build the long-press (o_Hold) counters; otherwise o_Hold is tied low.
module multi_debounce_filter #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned HOLD_LIMIT     = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Hold,
  output logic              o_Any_Change
);

  localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  if (NUM_CH < 1 || DEBOUNCE_LIMIT < 2 || HOLD_LIMIT < 1) begin : g_bad_params
    $error("multi_debounce_filter: parameter out of range");
  end

  logic [NUM_CH-1:0] sync_s1;
  logic [NUM_CH-1:0] sync_s2;
  logic [NUM_CH-1:0] load;

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= i_Bouncy;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_deb
    logic [CNT_W-1:0] cnt;

    // Accept the new level once it has disagreed with the output for DEBOUNCE_LIMIT edges
    assign load[ch] = (sync_s2[ch] != o_Debounced[ch]) && (cnt == CNT_MAX);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        cnt <= '0;
      end else if (sync_s2[ch] == o_Debounced[ch]) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Edge pulses are registered alongside the level so they line up with its first new cycle
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Debounced <= '0;
      o_Rise      <= '0;
      o_Fall      <= '0;
    end else begin
      o_Debounced <= o_Debounced ^ load;
      o_Rise      <= load & sync_s2;
      o_Fall      <= load & ~sync_s2;
    end
  end

  assign o_Any_Change = |(o_Rise | o_Fall);

`ifdef MULTI_DEBOUNCE_HOLD_EN
  localparam int unsigned HOLD_W = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT - 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_hold
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_q;

    // Saturating press timer; a falling load clears the flag on the same edge as the fall
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        hold_cnt <= '0;
        hold_q   <= 1'b0;
      end else if (!o_Debounced[ch] || load[ch]) begin
        hold_cnt <= '0;
        hold_q   <= 1'b0;
      end else if (hold_cnt == HOLD_MAX) begin
        hold_q   <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end

    assign o_Hold[ch] = hold_q;
  end
`else
  assign o_Hold = '0;
`endif

endmodule

// File: tb/tb_multi_debounce_filter.sv
// Directed bench for multi_debounce_filter (NUM_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=8).
// Hold expectations follow MULTI_DEBOUNCE_HOLD_EN as seen by this compilation.
module tb_multi_debounce_filter;

`ifdef MULTI_DEBOUNCE_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bouncy;
  logic [1:0] deb;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] hold;
  logic       any_chg;

  int n_pass  = 0;
  int n_total = 0;

  multi_debounce_filter #(
    .NUM_CH        (2),
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT    (8)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Bouncy    (bouncy),
    .o_Debounced (deb),
    .o_Rise      (rise),
    .o_Fall      (fall),
    .o_Hold      (hold),
    .o_Any_Change(any_chg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] hexp(input logic [1:0] h);
    return HOLD_ON ? h : 2'b00;
  endfunction

  task automatic chk_all(input string tag, input logic [1:0] d, input logic [1:0] r,
                         input logic [1:0] f, input logic [1:0] h);
    chk({tag, ".deb"},  8'(deb),     8'(d));
    chk({tag, ".rise"}, 8'(rise),    8'(r));
    chk({tag, ".fall"}, 8'(fall),    8'(f));
    chk({tag, ".hold"}, 8'(hold),    8'(h));
    chk({tag, ".any"},  8'(any_chg), 8'(|(r | f)));
  endtask

  initial begin
    rst    = 1'b1;
    bouncy = 2'b00;
    step();
    step();
    chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    // Single channel rise, long press, release
    bouncy = 2'b01;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk_all($sformatf("s1_rise_e%0d", i),
              (i >= 6) ? 2'b01 : 2'b00,
              (i == 6) ? 2'b01 : 2'b00,
              2'b00,
              hexp((i >= 14) ? 2'b01 : 2'b00));
    end
    bouncy = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_all($sformatf("s1_fall_e%0d", i),
              (i < 6) ? 2'b01 : 2'b00,
              2'b00,
              (i == 6) ? 2'b01 : 2'b00,
              hexp((i < 6) ? 2'b01 : 2'b00));
    end

    // Bounce 1,0 then settle high
    bouncy = 2'b01;
    step();
    chk_all("s2_b1", 2'b00, 2'b00, 2'b00, 2'b00);
    bouncy = 2'b00;
    step();
    chk_all("s2_b0", 2'b00, 2'b00, 2'b00, 2'b00);
    bouncy = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_all($sformatf("s2_rise_e%0d", i),
              (i >= 6) ? 2'b01 : 2'b00,
              (i == 6) ? 2'b01 : 2'b00,
              2'b00, 2'b00);
    end
    bouncy = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_all($sformatf("s2_fall_e%0d", i),
              (i < 6) ? 2'b01 : 2'b00,
              2'b00,
              (i == 6) ? 2'b01 : 2'b00,
              2'b00);
    end

    // Pulse one short of the limit must be rejected
    bouncy = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_all($sformatf("s3_hi_e%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);
    end
    bouncy = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_all($sformatf("s3_lo_e%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Both channels together
    bouncy = 2'b11;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_all($sformatf("s4_rise_e%0d", i),
              (i >= 6) ? 2'b11 : 2'b00,
              (i == 6) ? 2'b11 : 2'b00,
              2'b00, 2'b00);
    end
    bouncy = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_all($sformatf("s4_fall_e%0d", i),
              (i < 6) ? 2'b11 : 2'b00,
              2'b00,
              (i == 6) ? 2'b11 : 2'b00,
              2'b00);
    end

    // Reset mid-count with ch1 already debounced high
    bouncy = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_all($sformatf("s5_ch1_e%0d", i),
              (i >= 6) ? 2'b10 : 2'b00,
              (i == 6) ? 2'b10 : 2'b00,
              2'b00, 2'b00);
    end
    bouncy = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all($sformatf("s5_cnt_e%0d", i), 2'b10, 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b1;
    #2;
    chk_all("s5_async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk_all("s5_in_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_all($sformatf("s5_post_e%0d", i),
              (i >= 6) ? 2'b11 : 2'b00,
              (i == 6) ? 2'b11 : 2'b00,
              2'b00, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
